// File: rtl/sound_pkg.sv
// Shared types for the sound effect engine: sequencer states and note slot indices.
package sound_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        NOTE_A = 2'd1,
        NOTE_B = 2'd2
    } fx_state_t;

    localparam logic NOTE_A_IDX = 1'b0;
    localparam logic NOTE_B_IDX = 1'b1;

endpackage

// File: rtl/sound_tone_gen.sv
// Pitch divider plus sawtooth accumulator; one voice, cleared by the sequencer at note boundaries.
module sound_tone_gen #(
    parameter int DIV_W = 8,
    parameter int DAC_W = 8
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic             clear,
    input  logic [DIV_W-1:0] div,
    output logic [DAC_W-1:0] saw
);

    logic [DIV_W-1:0] div_cnt;

    // div == 0 is a rest: the sawtooth is pinned at zero for the whole note.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            div_cnt <= '0;
            saw     <= '0;
        end else if (clear || div == '0) begin
            div_cnt <= '0;
            saw     <= '0;
        end else if (div_cnt == div) begin
            div_cnt <= '0;
            saw     <= saw + 1'b1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sound_fx_engine.sv
// Prioritised two-note sound effect sequencer driving a sawtooth DAC code.
// Handshake-free: evt_req lines are level inputs, each rising edge is a request.
module sound_fx_engine
    import sound_pkg::*;
#(
    parameter int NUM_EVT = 4,
    parameter int DIV_W   = 8,
    parameter int DUR_W   = 24,
    parameter int DAC_W   = 8,
    parameter int EVT_IW  = $clog2(NUM_EVT)
) (
    input  logic                         clk,
    input  logic                         nRst,
    input  logic [NUM_EVT-1:0]           evt_req,
    input  logic                         mute,
    input  logic [NUM_EVT*2*DIV_W-1:0]   div_tbl,
    input  logic [NUM_EVT*2*DUR_W-1:0]   dur_tbl,
    output logic [DAC_W-1:0]             dac_out,
    output logic                         busy,
    output logic [EVT_IW-1:0]            active_evt
);

    fx_state_t          state, nxt;
    logic [NUM_EVT-1:0] prev, rise;
    logic               any_rise, entry, note_end, note_sel, tone_clear;
    logic [EVT_IW-1:0]  win, evt_sel;
    logic [EVT_IW:0]    slot;
    logic [DUR_W-1:0]   dur_cnt, cur_dur;
    logic [DIV_W-1:0]   cur_div;
    logic [DAC_W-1:0]   saw;

    // Highest-index rising request wins.
    always_comb begin
        rise     = evt_req & ~prev;
        any_rise = |rise;
        win      = '0;
        for (int i = 0; i < NUM_EVT; i++) begin
            if (rise[i]) win = EVT_IW'(i);
        end
    end

    assign note_end = (cur_dur == '0) || (dur_cnt == cur_dur - 1'b1);

    // A request arriving as NOTE_B finishes starts directly, whatever its priority.
    always_comb begin
        nxt      = state;
        entry    = 1'b0;
        evt_sel  = active_evt;
        note_sel = NOTE_A_IDX;
        case (state)
            IDLE: begin
                if (any_rise) begin
                    nxt     = NOTE_A;
                    entry   = 1'b1;
                    evt_sel = win;
                end
            end
            NOTE_A: begin
                if (any_rise && win >= active_evt) begin
                    nxt     = NOTE_A;
                    entry   = 1'b1;
                    evt_sel = win;
                end else if (note_end) begin
                    nxt      = NOTE_B;
                    entry    = 1'b1;
                    note_sel = NOTE_B_IDX;
                end
            end
            NOTE_B: begin
                if (any_rise && (win >= active_evt || note_end)) begin
                    nxt     = NOTE_A;
                    entry   = 1'b1;
                    evt_sel = win;
                end else if (note_end) begin
                    nxt = IDLE;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    assign slot       = {evt_sel, note_sel};
    assign tone_clear = entry || (nxt == IDLE);

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            active_evt <= '0;
            prev       <= '0;
            dur_cnt    <= '0;
            cur_dur    <= '0;
            cur_div    <= '0;
        end else begin
            state      <= nxt;
            busy       <= (nxt != IDLE);
            active_evt <= (nxt == IDLE) ? '0 : evt_sel;
            prev       <= evt_req;
            if (entry) begin
                cur_div <= div_tbl[int'(slot)*DIV_W +: DIV_W];
                cur_dur <= dur_tbl[int'(slot)*DUR_W +: DUR_W];
                dur_cnt <= '0;
            end else if (nxt == IDLE) begin
                cur_div <= '0;
                cur_dur <= '0;
                dur_cnt <= '0;
            end else begin
                dur_cnt <= dur_cnt + 1'b1;
            end
        end
    end

    sound_tone_gen #(
        .DIV_W (DIV_W),
        .DAC_W (DAC_W)
    ) u_tone (
        .clk   (clk),
        .nRst  (nRst),
        .clear (tone_clear),
        .div   (cur_div),
        .saw   (saw)
    );

    // Mute gates only the pins; the sawtooth keeps running underneath.
    assign dac_out = mute ? '0 : saw;

endmodule

// File: tb/tb_sound_fx_engine.sv
// Bench for sound_fx_engine: directed scenarios plus random traffic against a closed-form note model.
module tb_sound_fx_engine;

    localparam int NUM_EVT = 4;
    localparam int DIV_W   = 8;
    localparam int DUR_W   = 24;
    localparam int DAC_W   = 8;
    localparam int EVT_IW  = 2;

    logic                       clk = 1'b0;
    logic                       nRst = 1'b0;
    logic [NUM_EVT-1:0]         evt_req = '0;
    logic                       mute = 1'b0;
    logic [NUM_EVT*2*DIV_W-1:0] div_tbl = '0;
    logic [NUM_EVT*2*DUR_W-1:0] dur_tbl = '0;
    logic [DAC_W-1:0]           dac_out;
    logic                       busy;
    logic [EVT_IW-1:0]          active_evt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sound_fx_engine #(
        .NUM_EVT (NUM_EVT),
        .DIV_W   (DIV_W),
        .DUR_W   (DUR_W),
        .DAC_W   (DAC_W),
        .EVT_IW  (EVT_IW)
    ) dut (
        .clk        (clk),
        .nRst       (nRst),
        .evt_req    (evt_req),
        .mute       (mute),
        .div_tbl    (div_tbl),
        .dur_tbl    (dur_tbl),
        .dac_out    (dac_out),
        .busy       (busy),
        .active_evt (active_evt)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A note is described by its start: elapsed cycles, its divisor and length.
    // The expected sawtooth is elapsed/(div+1) modulo 2^DAC_W.
    bit                 m_busy;
    int                 m_evt, m_note, m_el, m_div, m_dur;
    logic [NUM_EVT-1:0] m_prev;

    function automatic int tbl_div(input int e, input int n);
        return int'(div_tbl[(e*2+n)*DIV_W +: DIV_W]);
    endfunction

    function automatic int tbl_dur(input int e, input int n);
        return int'(dur_tbl[(e*2+n)*DUR_W +: DUR_W]);
    endfunction

    task automatic m_reset();
        m_busy = 1'b0;
        m_evt  = 0;
        m_note = 0;
        m_el   = 0;
        m_div  = 0;
        m_dur  = 0;
        m_prev = '0;
    endtask

    task automatic m_start(input int e, input int n);
        m_busy = 1'b1;
        m_evt  = e;
        m_note = n;
        m_el   = 0;
        m_div  = tbl_div(e, n);
        m_dur  = tbl_dur(e, n);
    endtask

    task automatic m_step();
        int  w;
        int  len;
        bit  ending;
        w = -1;
        for (int i = 0; i < NUM_EVT; i++) begin
            if (evt_req[i] && !m_prev[i]) w = i;
        end
        m_prev = evt_req;
        len    = (m_dur == 0) ? 1 : m_dur;
        ending = m_busy && (m_el + 1 == len);
        if (!m_busy) begin
            if (w >= 0) m_start(w, 0);
        end else if (w >= 0 && (w >= m_evt || (m_note == 1 && ending))) begin
            m_start(w, 0);
        end else if (ending) begin
            if (m_note == 0) m_start(m_evt, 1);
            else m_busy = 1'b0;
        end else begin
            m_el++;
        end
    endtask

    function automatic int exp_dac();
        if (mute || !m_busy || m_div == 0) return 0;
        return (m_el / (m_div + 1)) % (1 << DAC_W);
    endfunction

    initial begin
        m_reset();
        forever begin
            @(negedge clk);
            if (nRst) begin
                chk("busy", int'(busy), int'(m_busy));
                chk("active_evt", int'(active_evt), m_busy ? m_evt : 0);
                chk("dac_out", int'(dac_out), exp_dac());
            end
            @(posedge clk);
            if (!nRst) m_reset();
            else m_step();
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic set_slot(input int e, input int n, input int dv, input int dr);
        div_tbl[(e*2+n)*DIV_W +: DIV_W] = DIV_W'(dv);
        dur_tbl[(e*2+n)*DUR_W +: DUR_W] = DUR_W'(dr);
    endtask

    task automatic wait_idle(input int lim);
        int n;
        n = 0;
        while (busy && n < lim) begin
            tick(1);
            n++;
        end
        chk("idle_timeout", int'(busy), 0);
        tick(2);
    endtask

    task automatic pulse_start(input int e);
        evt_req[e] = 1'b1;
        tick(1);
        evt_req[e] = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int e = 0; e < NUM_EVT; e++) begin
            set_slot(e, 0, 1, 4);
            set_slot(e, 1, 2, 4);
        end
        tick(2);
        nRst = 1'b1;
        tick(2);
        chk("reset_busy", int'(busy), 0);
        chk("reset_dac", int'(dac_out), 0);
        chk("reset_active", int'(active_evt), 0);

        // Basic two-note sequence on event 0.
        set_slot(0, 0, 3, 20);
        set_slot(0, 1, 1, 10);
        pulse_start(0);
        chk("t1_busy_rise", int'(busy), 1);
        chk("t1_dac_start", int'(dac_out), 0);
        tick(12);
        chk("t1_dac_a_k12", int'(dac_out), 3);
        tick(7);
        chk("t1_dac_a_k19", int'(dac_out), 4);
        tick(3);
        chk("t1_dac_b_k2", int'(dac_out), 1);
        tick(7);
        chk("t1_busy_last", int'(busy), 1);
        tick(1);
        chk("t1_busy_end", int'(busy), 0);
        chk("t1_dac_end", int'(dac_out), 0);
        wait_idle(100);

        // Simultaneous requests: highest index wins.
        set_slot(2, 0, 1, 6);
        set_slot(2, 1, 1, 6);
        evt_req = 4'b0101;
        tick(1);
        evt_req = '0;
        chk("t2_priority", int'(active_evt), 2);
        wait_idle(100);

        // Preemption by a higher event, then a lower one is dropped.
        set_slot(1, 0, 2, 40);
        set_slot(1, 1, 1, 5);
        set_slot(3, 0, 1, 12);
        set_slot(3, 1, 1, 6);
        pulse_start(1);
        tick(9);
        chk("t3_evt1_active", int'(active_evt), 1);
        chk("t3_evt1_dac", int'(dac_out), 3);
        pulse_start(3);
        chk("t3_preempt_evt", int'(active_evt), 3);
        chk("t3_preempt_dac", int'(dac_out), 0);
        tick(2);
        chk("t3_evt3_dac", int'(dac_out), 1);
        pulse_start(0);
        chk("t3_low_ignored", int'(active_evt), 3);
        wait_idle(100);

        // Zero-length note B passes in one cycle.
        set_slot(2, 0, 1, 6);
        set_slot(2, 1, 2, 0);
        pulse_start(2);
        tick(5);
        chk("t4_dac_a_k5", int'(dac_out), 2);
        tick(1);
        chk("t4_skip_busy", int'(busy), 1);
        tick(1);
        chk("t4_idle_after", int'(busy), 0);
        wait_idle(100);

        // Rest note: divisor zero.
        set_slot(1, 0, 0, 8);
        set_slot(1, 1, 1, 2);
        pulse_start(1);
        tick(4);
        chk("t4_rest_dac", int'(dac_out), 0);
        chk("t4_rest_busy", int'(busy), 1);
        wait_idle(100);

        // Sawtooth wrap.
        set_slot(0, 0, 1, 600);
        set_slot(0, 1, 1, 1);
        pulse_start(0);
        tick(510);
        chk("t4_wrap_255", int'(dac_out), 255);
        tick(2);
        chk("t4_wrap_0", int'(dac_out), 0);
        tick(2);
        chk("t4_wrap_1", int'(dac_out), 1);
        wait_idle(1000);

        // Held level request triggers once.
        set_slot(1, 0, 2, 20);
        set_slot(1, 1, 1, 20);
        evt_req[1] = 1'b1;
        tick(60);
        chk("t5_held_once", int'(busy), 0);
        tick(40);
        evt_req[1] = 1'b0;
        tick(2);

        // Mute mid-note; sawtooth keeps counting underneath.
        set_slot(3, 0, 1, 30);
        set_slot(3, 1, 1, 4);
        pulse_start(3);
        tick(10);
        chk("t5_pre_mute", int'(dac_out), 5);
        mute = 1'b1;
        #1;
        chk("t5_muted_dac", int'(dac_out), 0);
        chk("t5_muted_busy", int'(busy), 1);
        tick(4);
        mute = 1'b0;
        #1;
        chk("t5_unmuted_dac", int'(dac_out), 7);
        wait_idle(100);

        // Asynchronous reset during note B.
        set_slot(0, 0, 3, 20);
        set_slot(0, 1, 1, 10);
        pulse_start(0);
        tick(24);
        chk("t6_in_note_b", int'(busy), 1);
        #2;
        nRst = 1'b0;
        #1;
        chk("t6_rst_dac", int'(dac_out), 0);
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_active", int'(active_evt), 0);
        tick(1);
        nRst = 1'b1;
        tick(20);
        chk("t6_silent_busy", int'(busy), 0);
        chk("t6_silent_dac", int'(dac_out), 0);

        // Random traffic.
        for (int e = 0; e < NUM_EVT; e++) begin
            for (int n = 0; n < 2; n++) set_slot(e, n, $urandom_range(0, 4), $urandom_range(0, 12));
        end
        for (int c = 0; c < 4000; c++) begin
            int r;
            int i;
            r = $urandom_range(0, 99);
            if (r < 8) begin
                i = $urandom_range(0, NUM_EVT-1);
                evt_req[i] = ~evt_req[i];
            end else if (r < 12) begin
                set_slot($urandom_range(0, NUM_EVT-1), $urandom_range(0, 1),
                         $urandom_range(0, 4), $urandom_range(0, 12));
            end else if (r < 14) begin
                mute = ~mute;
            end
            tick(1);
        end
        evt_req = '0;
        mute    = 1'b0;
        wait_idle(200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
